// File: rtl/snoopy_bus_arbiter.sv
`timescale 1ns/1ps
// snoopy_bus_arbiter
//   Round-robin owner selection and transaction sequencing for the shared
//   snoopy bus. One cache owns the bus at a time. Its memory transaction is
//   started, and when the transaction hit a valid line, an invalidate is
//   broadcast to every other cache. The bus is released once all of those
//   caches have acked.
//
//   Optional build macro: SNOOPY_ARBITER_WATCHDOG_EN
//     When defined, an ack collection that lasts too long is aborted after
//     ACK_TIMEOUT SNOOP cycles. The abort pulses error, and done still follows.
//     When undefined, SNOOP waits for acks forever and error is tied low.
//
// Ports
//   clock        bus clock, rising edge
//   reset        asynchronous, active-low
//   request      per-cache level request, held until done
//   invalidate   per-cache invalidate-needed flag, sampled when the owner is picked
//   grant        one-hot bus owner, held from GRANT through RELEASE
//   memoryStart  one-cycle pulse when the owner's memory transaction begins
//   memoryDone   one-cycle memory completion pulse, honoured only in MEMORY
//   snoopValid   invalidate broadcast active
//   snoopTarget  caches that must ack (everyone but the owner)
//   snoopAck     per-cache ack, level or pulse, honoured only in SNOOP
//   done         one-hot one-cycle pulse to the owner at release
//   busy         arbiter not idle
//   error        one-cycle pulse on watchdog abort
module snoopy_bus_arbiter #(
  parameter int NUMBER_OF_CACHES = 4,
  parameter int ACK_TIMEOUT      = 15
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUMBER_OF_CACHES-1:0] request,
  input  logic [NUMBER_OF_CACHES-1:0] invalidate,
  output logic [NUMBER_OF_CACHES-1:0] grant,
  output logic                        memoryStart,
  input  logic                        memoryDone,
  output logic                        snoopValid,
  output logic [NUMBER_OF_CACHES-1:0] snoopTarget,
  input  logic [NUMBER_OF_CACHES-1:0] snoopAck,
  output logic [NUMBER_OF_CACHES-1:0] done,
  output logic                        busy,
  output logic                        error
);

  localparam int N  = NUMBER_OF_CACHES;
  localparam int PW = $clog2(N);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_MEMORY  = 3'd2;
  localparam logic [2:0] ST_SNOOP   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pointer_q, pointer_d;
  logic [N-1:0]  owner_q, owner_d;
  logic          need_inv_q, need_inv_d;
  logic [N-1:0]  ack_seen_q, ack_seen_d;

  logic [N-1:0]  pick;
  logic [PW-1:0] owner_idx;
  logic [N-1:0]  ack_all;
  logic          acks_complete;
  logic          err;
  int            j;

`ifdef SNOOPY_ARBITER_WATCHDOG_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] counter_q, counter_d;
`endif

  // Rotating priority: the first requester at or after the pointer wins.
  always_comb begin
    pick = '0;
    j    = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(pointer_q) + i) % N;
      if (pick == '0 && request[j]) pick[j] = 1'b1;
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N; i++)
      if (owner_q[i]) owner_idx = PW'(i);
  end

  // Acks arriving in the current cycle count toward completion. The owner's
  // own ack bit is masked so it can never satisfy its own broadcast.
  assign ack_all       = (ack_seen_q | snoopAck) & ~owner_q;
  assign acks_complete = (ack_all == ~owner_q);

  always_comb begin
    state_d    = state_q;
    pointer_d  = pointer_q;
    owner_d    = owner_q;
    need_inv_d = need_inv_q;
    ack_seen_d = ack_seen_q;
    err        = 1'b0;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
    counter_d  = counter_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|request) begin
          owner_d    = pick;
          need_inv_d = |(invalidate & pick);
          ack_seen_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_MEMORY;
      ST_MEMORY: begin
        if (memoryDone) begin
          state_d = need_inv_q ? ST_SNOOP : ST_RELEASE;
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
          counter_d = '0;
`endif
        end
      end
      ST_SNOOP: begin
        ack_seen_d = ack_all;
        if (acks_complete) begin
          state_d = ST_RELEASE;
        end
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
        else if (counter_q == CW'(ACK_TIMEOUT)) begin
          err     = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          counter_d = counter_q + CW'(1);
        end
`endif
      end
      ST_RELEASE: begin
        pointer_d  = (owner_idx == PW'(N - 1)) ? '0 : owner_idx + PW'(1);
        ack_seen_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pointer_q  <= '0;
      owner_q    <= '0;
      need_inv_q <= 1'b0;
      ack_seen_q <= '0;
    end else begin
      state_q    <= state_d;
      pointer_q  <= pointer_d;
      owner_q    <= owner_d;
      need_inv_q <= need_inv_d;
      ack_seen_q <= ack_seen_d;
    end
  end

`ifdef SNOOPY_ARBITER_WATCHDOG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) counter_q <= '0;
    else        counter_q <= counter_d;
  end
  assign error = err;
`else
  assign error = 1'b0;
`endif

  // All outputs decode straight from flops (plus err), so an asynchronous
  // reset drops them at once.
  assign busy        = (state_q != ST_IDLE);
  assign grant       = busy ? owner_q : '0;
  assign memoryStart = (state_q == ST_GRANT);
  assign snoopValid  = (state_q == ST_SNOOP);
  assign snoopTarget = snoopValid ? ~owner_q : '0;
  assign done        = (state_q == ST_RELEASE) ? owner_q : '0;

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
`timescale 1ns/1ps
module tb_snoopy_bus_arbiter;
  localparam int N = 4;

  logic         clock, reset;
  logic [N-1:0] request, invalidate, grant, snoopTarget, snoopAck, done;
  logic         memoryStart, memoryDone, snoopValid, busy, error;

  int n_chk  = 0;
  int n_pass = 0;
  logic [N-1:0] q_start[$];
  logic [N-1:0] q_done[$];

  snoopy_bus_arbiter #(.NUMBER_OF_CACHES(N), .ACK_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .request(request), .invalidate(invalidate),
    .grant(grant), .memoryStart(memoryStart), .memoryDone(memoryDone),
    .snoopValid(snoopValid), .snoopTarget(snoopTarget), .snoopAck(snoopAck),
    .done(done), .busy(busy), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops an expectation whenever the DUT starts or finishes a transaction.
  always @(negedge clock) begin
    if (reset) begin
      if (memoryStart) begin
        if (q_start.size() == 0) chk("unexpected_start", {28'd0, grant}, 32'hFFFF);
        else chk("start_grant", {28'd0, grant}, {28'd0, q_start.pop_front()});
      end
      if (|done) begin
        if (q_done.size() == 0) chk("unexpected_done", {28'd0, done}, 32'hFFFF);
        else begin
          logic [N-1:0] e;
          e = q_done.pop_front();
          chk("done_owner", {28'd0, done}, {28'd0, e});
          chk("done_grant", {28'd0, grant}, {28'd0, e});
        end
      end
    end
  end

  task automatic wait_start();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (memoryStart) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("wait_start_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (|done) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("wait_done_timeout", 0, 1);
  endtask

  // Called in the GRANT cycle; returns in the cycle after MEMORY.
  task automatic mem_pulse(input int w);
    repeat (w) tick();
    memoryDone = 1'b1;
    tick();
    memoryDone = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; request = '0; invalidate = '0; memoryDone = 1'b0; snoopAck = '0;
    tick(); tick();
    chk("rst_grant", {28'd0, grant}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {28'd0, done}, 0);
    chk("rst_mstart", {31'd0, memoryStart}, 0);
    chk("rst_snoop", {31'd0, snoopValid}, 0);
    chk("rst_error", {31'd0, error}, 0);
    reset = 1'b1;
    tick();

    // Single request, memory answers 3 cycles into MEMORY.
    q_start.push_back(4'b0010); q_done.push_back(4'b0010);
    request = 4'b0010;
    tick();
    chk("t1_grant_cycle1", {28'd0, grant}, 4'b0010);
    wait_start();
    mem_pulse(3);
    wait_done();
    request = '0;
    tick();
    chk("t1_busy_after", {31'd0, busy}, 0);
    chk("t1_grant_after", {28'd0, grant}, 0);

    // Pointer now 2: 0110 must pick cache 2, not cache 1.
    q_start.push_back(4'b0100); q_done.push_back(4'b0100);
    request = 4'b0110;
    wait_start();
    mem_pulse(1);
    wait_done();
    request = '0;
    tick();

    // All request from reset: strict rotation.
    do_reset();
    foreach (q_start[i]) ; // queues are already empty here
    q_start.push_back(4'b0001); q_start.push_back(4'b0010); q_start.push_back(4'b0100);
    q_start.push_back(4'b1000); q_start.push_back(4'b0001);
    q_done.push_back(4'b0001); q_done.push_back(4'b0010); q_done.push_back(4'b0100);
    q_done.push_back(4'b1000); q_done.push_back(4'b0001);
    request = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_start();
      mem_pulse(2);
      wait_done();
      if (t == 4) request = '0;
      tick();
      chk("rr_idle_gap", {31'd0, busy}, 0);
    end

    // Invalidate broadcast with acks split across two cycles.
    q_start.push_back(4'b0001); q_done.push_back(4'b0001);
    request = 4'b0001; invalidate = 4'b0001;
    wait_start();
    invalidate = '0;
    mem_pulse(1);
    chk("t3_snoop_valid", {31'd0, snoopValid}, 1);
    chk("t3_snoop_target", {28'd0, snoopTarget}, 4'b1110);
    snoopAck = 4'b0010;
    tick();
    chk("t3_still_snoop", {31'd0, snoopValid}, 1);
    chk("t3_no_early_done", {28'd0, done}, 0);
    snoopAck = 4'b1100;
    tick();
    snoopAck = '0;
    chk("t3_release", {28'd0, done}, 4'b0001);
    chk("t3_snoop_off", {31'd0, snoopValid}, 0);
    request = '0;
    tick();

    // All acks in the first SNOOP cycle, including the owner's own bit.
    q_start.push_back(4'b0010); q_done.push_back(4'b0010);
    request = 4'b0010; invalidate = 4'b0010;
    wait_start();
    invalidate = '0;
    mem_pulse(1);
    chk("t4_target", {28'd0, snoopTarget}, 4'b1101);
    snoopAck = 4'b1111;
    tick();
    snoopAck = '0;
    chk("t4_release", {28'd0, done}, 4'b0010);
    request = '0;
    tick();

    // Stray memoryDone / snoopAck while idle are ignored.
    memoryDone = 1'b1; snoopAck = 4'b1111;
    tick();
    memoryDone = 1'b0; snoopAck = '0;
    tick();
    chk("stray_busy", {31'd0, busy}, 0);

    // Reset during MEMORY drops everything; arbitration restarts at pointer 0.
    q_start.push_back(4'b0100);
    request = 4'b0100;
    wait_start();
    tick();
    reset = 1'b0;
    #1;
    chk("rstmem_grant", {28'd0, grant}, 0);
    chk("rstmem_busy", {31'd0, busy}, 0);
    chk("rstmem_snoop", {31'd0, snoopValid}, 0);
    tick();
    reset = 1'b1;
    q_start.push_back(4'b0010); q_done.push_back(4'b0010);
    request = 4'b0110;
    wait_start();
    mem_pulse(1);
    wait_done();
    request = '0;
    tick();

    // No acks at all.
    q_start.push_back(4'b0001);
    request = 4'b0001; invalidate = 4'b0001;
    wait_start();
    invalidate = '0;
    mem_pulse(1);
`ifdef SNOOPY_ARBITER_WATCHDOG_EN
    begin
      int k;
      q_done.push_back(4'b0001);
      for (k = 0; k < 30; k++) begin
        if (error) break;
        tick();
      end
      chk("wd_error_cycle", k, 15);
      tick();
      chk("wd_done", {28'd0, done}, 4'b0001);
      chk("wd_error_pulse", {31'd0, error}, 0);
      request = '0;
      tick();
    end
`else
    begin
      bit seen_err = 0;
      for (int k = 0; k < 20; k++) begin
        seen_err |= error;
        tick();
      end
      chk("noack_still_snoop", {31'd0, snoopValid}, 1);
      chk("noack_no_error", {31'd0, seen_err}, 0);
      request = '0;
      do_reset();
    end
`endif

    chk("queues_drained", q_start.size() + q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
